// File: rtl/mx_shared_exp_align.sv
// Buffers one block of sign/exponent/mantissa elements, finds the shared (maximum
// effective) exponent, then replays the block as signed mantissas with per-element shifts.
module mx_shared_exp_align #(
  parameter int width_e     = 8,
  parameter int width_m     = 7,
  parameter int width_i     = width_m + 2,
  parameter int width_o     = 8,
  parameter int width_shift = $clog2(width_i + 2),
  parameter int block_size  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_sign,
  input  logic [width_e-1:0]     i_exp,
  input  logic [width_m-1:0]     i_man,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [width_i-1:0]     o_num,
  output logic [width_shift-1:0] o_shift,
  output logic [width_e-1:0]     o_scale,
  output logic                   o_first,
  output logic                   o_last
);

  localparam int cnt_w   = $clog2(block_size);
  localparam int entry_w = 1 + width_e + 1 + width_m;
  localparam logic [cnt_w-1:0]       last_idx   = cnt_w'(block_size - 1);
  localparam logic [width_e-1:0]     exp_ones   = '1;
  localparam logic [width_e-1:0]     exp_one    = width_e'(1);
  localparam logic [width_e-1:0]     sat_thresh = width_e'(width_o);
  localparam logic [width_shift-1:0] sat_shift  = width_shift'(width_o + 1);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t                state_reg;
  logic [cnt_w-1:0]      wr_cnt_reg;
  logic [cnt_w-1:0]      rd_cnt_reg;
  logic [width_e-1:0]    max_exp_reg;
  logic                  valid_reg;
  logic                  ready_reg;
  logic [entry_w-1:0]    buffer [block_size];
  logic [entry_w-1:0]    rd_data_reg;

  // Element decode: denormals take exponent 1 with no hidden bit; Inf/NaN saturate
  // to the largest finite magnitude.
  logic                  in_is_inf;
  logic [width_e-1:0]    in_eff_exp;
  logic                  in_hidden;
  logic [width_m-1:0]    in_man;
  logic [entry_w-1:0]    in_entry;
  logic [width_e-1:0]    max_exp_next;

  always_comb begin
    in_is_inf  = (i_exp == exp_ones);
    in_hidden  = (i_exp != '0);
    in_eff_exp = i_exp;
    in_man     = i_man;
    if (i_exp == '0) begin
      in_eff_exp = exp_one;
    end else if (in_is_inf) begin
      in_eff_exp = exp_ones - exp_one;
      in_man     = '1;
    end
    in_entry     = {i_sign, in_eff_exp, in_hidden, in_man};
    max_exp_next = (in_eff_exp > max_exp_reg) ? in_eff_exp : max_exp_reg;
  end

  logic             wr_en;
  logic             wr_last;
  logic             rd_last;
  logic [cnt_w-1:0] rd_addr;

  always_comb begin
    wr_en   = (state_reg == S_FILL) && i_valid;
    wr_last = (wr_cnt_reg == last_idx);
    rd_last = (rd_cnt_reg == last_idx);
    // Prefetch the next element on a handshake so data is ready the following cycle.
    rd_addr = rd_cnt_reg;
    if (state_reg == S_DRAIN && i_ready) begin
      rd_addr = rd_last ? '0 : rd_cnt_reg + cnt_w'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      buffer[wr_cnt_reg] <= in_entry;
    end
    rd_data_reg <= buffer[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= S_FILL;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      max_exp_reg <= '0;
      valid_reg   <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      case (state_reg)
        S_FILL: begin
          if (i_valid) begin
            max_exp_reg <= max_exp_next;
            if (wr_last) begin
              wr_cnt_reg <= '0;
              state_reg  <= S_DRAIN;
              valid_reg  <= 1'b1;
              ready_reg  <= 1'b0;
            end else begin
              wr_cnt_reg <= wr_cnt_reg + cnt_w'(1);
            end
          end
        end
        S_DRAIN: begin
          if (i_ready) begin
            if (rd_last) begin
              rd_cnt_reg  <= '0;
              max_exp_reg <= '0;
              state_reg   <= S_FILL;
              valid_reg   <= 1'b0;
              ready_reg   <= 1'b1;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + cnt_w'(1);
            end
          end
        end
        default: state_reg <= S_FILL;
      endcase
    end
  end

  logic                 rd_sign;
  logic [width_e-1:0]   rd_eff_exp;
  logic                 rd_hidden;
  logic [width_m-1:0]   rd_man;
  logic [width_i-1:0]   rd_mag;
  logic [width_i-1:0]   rd_num;
  logic [width_e-1:0]   exp_diff;

  always_comb begin
    {rd_sign, rd_eff_exp, rd_hidden, rd_man} = rd_data_reg;
    rd_mag   = width_i'({1'b0, rd_hidden, rd_man});
    rd_num   = rd_sign ? (~rd_mag + width_i'(1)) : rd_mag;
    exp_diff = max_exp_reg - rd_eff_exp;
    o_valid  = valid_reg;
    o_ready  = ready_reg;
    o_num    = '0;
    o_shift  = '0;
    o_scale  = '0;
    o_first  = 1'b0;
    o_last   = 1'b0;
    if (valid_reg) begin
      o_num   = rd_num;
      // Shifting past the output width would still leave rounding bits; the
      // saturated value tells the rounding stage to flush the element to zero.
      o_shift = (exp_diff > sat_thresh) ? sat_shift : exp_diff[width_shift-1:0];
      o_scale = max_exp_reg;
      o_first = (rd_cnt_reg == '0);
      o_last  = rd_last;
    end
  end

endmodule

// File: tb/tb_mx_shared_exp_align.sv
// Directed bench for mx_shared_exp_align with block_size=4 and hand-computed expectations.
module tb_mx_shared_exp_align;

  localparam int BS = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       i_sign = 1'b0;
  logic [7:0] i_exp = '0;
  logic [6:0] i_man = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [8:0] o_num;
  logic [3:0] o_shift;
  logic [7:0] o_scale;
  logic       o_first;
  logic       o_last;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_num   [BS];
  int exp_shift [BS];
  int exp_scale;

  mx_shared_exp_align #(.block_size(BS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .o_valid(o_valid),
    .i_ready(i_ready), .o_num(o_num), .o_shift(o_shift), .o_scale(o_scale),
    .o_first(o_first), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_ready"}, int'(o_ready), 1);
    check({tag, "_num"},   int'(o_num),   0);
    check({tag, "_shift"}, int'(o_shift), 0);
    check({tag, "_scale"}, int'(o_scale), 0);
    check({tag, "_first"}, int'(o_first), 0);
    check({tag, "_last"},  int'(o_last),  0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic push(input logic s, input int e, input int m);
    i_valid = 1'b1;
    i_sign  = s;
    i_exp   = 8'(e);
    i_man   = 7'(m);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic check_elem(input string tag, input int k);
    check({tag, "_valid"}, int'(o_valid), 1);
    check({tag, "_ready"}, int'(o_ready), 0);
    check({tag, "_num"},   int'($signed(o_num)), exp_num[k]);
    check({tag, "_shift"}, int'(o_shift), exp_shift[k]);
    check({tag, "_scale"}, int'(o_scale), exp_scale);
    check({tag, "_first"}, int'(o_first), (k == 0) ? 1 : 0);
    check({tag, "_last"},  int'(o_last),  (k == BS - 1) ? 1 : 0);
  endtask

  // Drains n elements; when stall_idx matches, i_ready is held low for 3 cycles
  // while junk i_valid beats are offered.
  task automatic drain(input string tag, input int n, input int stall_idx);
    for (int k = 0; k < n; k++) begin
      check_elem($sformatf("%s_e%0d", tag, k), k);
      if (k == stall_idx) begin
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          i_valid = 1'b1;
          i_sign  = 1'b0;
          i_exp   = 8'd250;
          i_man   = 7'd99;
          tick();
          check_elem($sformatf("%s_stall%0d", tag, c), k);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
      end
      $display("%s element %0d: num=%0d shift=%0d scale=%0d", tag, k,
               $signed(o_num), o_shift, o_scale);
      tick();
    end
  endtask

  task automatic set_exp(input int n0, input int n1, input int n2, input int n3,
                         input int s0, input int s1, input int s2, input int s3,
                         input int sc);
    exp_num[0] = n0; exp_num[1] = n1; exp_num[2] = n2; exp_num[3] = n3;
    exp_shift[0] = s0; exp_shift[1] = s1; exp_shift[2] = s2; exp_shift[3] = s3;
    exp_scale = sc;
  endtask

  task automatic block_basic(input string tag);
    push(1'b0, 127, 0);
    push(1'b1, 128, 0);
    push(1'b0, 126, 0);
    check({tag, "_pre_valid"}, int'(o_valid), 0);
    push(1'b0, 127, 64);
    set_exp(128, -128, 128, 192, 1, 0, 2, 1, 128);
    drain(tag, BS, -1);
    check({tag, "_post_valid"}, int'(o_valid), 0);
    check({tag, "_post_ready"}, int'(o_ready), 1);
  endtask

  initial begin
    i_ready = 1'b1;
    do_reset();
    check_reset_outputs("rst0");

    block_basic("basic");

    push(1'b0, 140, 0);
    push(1'b0, 132, 0);
    push(1'b0, 120, 0);
    push(1'b0, 140, 0);
    set_exp(128, 128, 128, 128, 0, 8, 9, 0, 140);
    drain("sat", BS, -1);

    push(1'b0, 0, 5);
    push(1'b0, 1, 0);
    push(1'b1, 0, 5);
    push(1'b0, 1, 0);
    set_exp(5, 128, -5, 128, 0, 0, 0, 0, 1);
    drain("denorm", BS, -1);

    for (int k = 0; k < BS; k++) push(1'b0, 0, 0);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drain("zero", BS, -1);

    push(1'b1, 255, 0);
    push(1'b0, 254, 0);
    push(1'b0, 127, 0);
    push(1'b1, 255, 3);
    set_exp(-255, 128, 128, -255, 0, 0, 9, 0, 254);
    drain("inf_stall", BS, 2);

    // Junk beats during the stall must not have shifted the fill pointer.
    block_basic("after_stall");

    push(1'b0, 200, 0);
    push(1'b0, 200, 0);
    do_reset();
    check_reset_outputs("rst_fill");
    block_basic("after_rst_fill");

    push(1'b0, 140, 0);
    push(1'b0, 132, 0);
    push(1'b0, 120, 0);
    push(1'b0, 140, 0);
    set_exp(128, 128, 128, 128, 0, 8, 9, 0, 140);
    drain("part", 2, -1);
    do_reset();
    check_reset_outputs("rst_drain");
    block_basic("after_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
